// File: rtl/rs_multi_entry_if.sv
// Dispatch, CDB and issue-side bus of the multi-entry reservation station.
// master: the surrounding pipeline (dispatch, CDB, functional unit).
// slave : the reservation station itself.
interface rs_multi_entry_if #(
    parameter int RS_DEPTH  = 8,
    parameter int XLEN      = 32,
    parameter int TAG_W     = 5,
    parameter int PAYLOAD_W = 96
);
    localparam int CNT_W = $clog2(RS_DEPTH + 1);

    logic                 squash;

    logic                 disp_valid;
    logic                 disp_ready;
    logic [PAYLOAD_W-1:0] disp_payload;
    logic [TAG_W-1:0]     disp_tag;
    logic                 disp_rs1_ready;
    logic                 disp_rs2_ready;
    logic [XLEN-1:0]      disp_rs1_value;
    logic [XLEN-1:0]      disp_rs2_value;
    logic [TAG_W-1:0]     disp_rs1_tag;
    logic [TAG_W-1:0]     disp_rs2_tag;

    logic                 cdb_valid;
    logic [TAG_W-1:0]     cdb_tag;
    logic [XLEN-1:0]      cdb_value;

    logic                 issue_valid;
    logic                 issue_ready;
    logic [PAYLOAD_W-1:0] issue_payload;
    logic [TAG_W-1:0]     issue_tag;
    logic [XLEN-1:0]      issue_rs1_value;
    logic [XLEN-1:0]      issue_rs2_value;

    logic [CNT_W-1:0]     free_count;

    modport master (
        output squash,
        output disp_valid, disp_payload, disp_tag,
        output disp_rs1_ready, disp_rs2_ready, disp_rs1_value, disp_rs2_value,
        output disp_rs1_tag, disp_rs2_tag,
        output cdb_valid, cdb_tag, cdb_value,
        output issue_ready,
        input  disp_ready,
        input  issue_valid, issue_payload, issue_tag, issue_rs1_value, issue_rs2_value,
        input  free_count
    );

    modport slave (
        input  squash,
        input  disp_valid, disp_payload, disp_tag,
        input  disp_rs1_ready, disp_rs2_ready, disp_rs1_value, disp_rs2_value,
        input  disp_rs1_tag, disp_rs2_tag,
        input  cdb_valid, cdb_tag, cdb_value,
        input  issue_ready,
        output disp_ready,
        output issue_valid, issue_payload, issue_tag, issue_rs1_value, issue_rs2_value,
        output free_count
    );
endinterface

// File: rtl/rs_multi_entry.sv
// Multi-entry reservation station for one functional-unit class.
// Entries capture operands from the CDB; the oldest fully-ready entry is
// moved into a registered valid/ready output stage. Age order is kept in an
// age matrix: r_older[i][j] = 1 means entry j was dispatched before entry i.
module rs_multi_entry #(
    parameter int RS_DEPTH  = 8,
    parameter int XLEN      = 32,
    parameter int TAG_W     = 5,
    parameter int PAYLOAD_W = 96
) (
    input  logic            clock,
    input  logic            reset,
    rs_multi_entry_if.slave bus
);
    localparam int CNT_W = $clog2(RS_DEPTH + 1);
    localparam int IDX_W = $clog2(RS_DEPTH);

    // entry control state
    logic [RS_DEPTH-1:0]  r_valid;
    logic [RS_DEPTH-1:0]  r_rdy1;
    logic [RS_DEPTH-1:0]  r_rdy2;
    logic [RS_DEPTH-1:0]  r_older [RS_DEPTH];
    logic [CNT_W-1:0]     r_free_count;

    // entry data state
    logic [PAYLOAD_W-1:0] r_payload [RS_DEPTH];
    logic [TAG_W-1:0]     r_tag     [RS_DEPTH];
    logic [TAG_W-1:0]     r_tag1    [RS_DEPTH];
    logic [TAG_W-1:0]     r_tag2    [RS_DEPTH];
    logic [XLEN-1:0]      r_val1    [RS_DEPTH];
    logic [XLEN-1:0]      r_val2    [RS_DEPTH];

    // output stage
    logic                 r_issue_valid;
    logic [PAYLOAD_W-1:0] r_issue_payload;
    logic [TAG_W-1:0]     r_issue_tag;
    logic [XLEN-1:0]      r_issue_rs1;
    logic [XLEN-1:0]      r_issue_rs2;

    logic [RS_DEPTH-1:0]  w_elig;
    logic [RS_DEPTH-1:0]  w_sel_oh;
    logic [IDX_W-1:0]     w_sel_idx;
    logic                 w_any_elig;
    logic [IDX_W-1:0]     w_free_idx;
    logic [RS_DEPTH-1:0]  w_wake1;
    logic [RS_DEPTH-1:0]  w_wake2;
    logic                 w_disp_ready;
    logic                 w_disp_fire;
    logic                 w_out_open;
    logic                 w_load;
    logic                 w_byp1;
    logic                 w_byp2;
    logic                 w_d_rdy1;
    logic                 w_d_rdy2;
    logic [XLEN-1:0]      w_d_val1;
    logic [XLEN-1:0]      w_d_val2;

    // handshake decisions; disp_ready depends only on registered state
    assign w_disp_ready = (r_free_count != '0);
    assign w_disp_fire  = bus.disp_valid && w_disp_ready && !bus.squash;
    assign w_elig       = r_valid & r_rdy1 & r_rdy2;
    assign w_any_elig   = |w_elig;
    assign w_out_open   = !r_issue_valid || bus.issue_ready;
    assign w_load       = w_out_open && w_any_elig;

    // an operand waiting on the tag being broadcast this cycle is captured at dispatch
    assign w_byp1   = !bus.disp_rs1_ready && bus.cdb_valid && (bus.cdb_tag == bus.disp_rs1_tag);
    assign w_byp2   = !bus.disp_rs2_ready && bus.cdb_valid && (bus.cdb_tag == bus.disp_rs2_tag);
    assign w_d_rdy1 = bus.disp_rs1_ready || w_byp1;
    assign w_d_rdy2 = bus.disp_rs2_ready || w_byp2;
    assign w_d_val1 = bus.disp_rs1_ready ? bus.disp_rs1_value : bus.cdb_value;
    assign w_d_val2 = bus.disp_rs2_ready ? bus.disp_rs2_value : bus.cdb_value;

    // oldest eligible entry: eligible with no older eligible entry
    always_comb begin
        w_sel_oh  = '0;
        w_sel_idx = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (w_elig[i] && ((r_older[i] & w_elig) == '0)) begin
                w_sel_oh[i] = 1'b1;
                w_sel_idx   = IDX_W'(i);
            end
        end
    end

    // lowest-index free entry, taken from registered valid bits
    always_comb begin
        w_free_idx = '0;
        for (int i = RS_DEPTH - 1; i >= 0; i--) begin
            if (!r_valid[i]) w_free_idx = IDX_W'(i);
        end
    end

    // CDB tag match for every waiting operand
    always_comb begin
        w_wake1 = '0;
        w_wake2 = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            w_wake1[i] = bus.cdb_valid && r_valid[i] && !r_rdy1[i] && (r_tag1[i] == bus.cdb_tag);
            w_wake2[i] = bus.cdb_valid && r_valid[i] && !r_rdy2[i] && (r_tag2[i] == bus.cdb_tag);
        end
    end

    // entry valid/ready bits, age matrix and free counter; squash beats everything
    always_ff @(posedge clock) begin
        if (reset || bus.squash) begin
            r_valid      <= '0;
            r_free_count <= CNT_W'(RS_DEPTH);
        end else begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                if (w_disp_fire && (w_free_idx == IDX_W'(i))) begin
                    r_valid[i] <= 1'b1;
                    r_rdy1[i]  <= w_d_rdy1;
                    r_rdy2[i]  <= w_d_rdy2;
                end else begin
                    if (w_load && w_sel_oh[i]) r_valid[i] <= 1'b0;
                    if (w_wake1[i])            r_rdy1[i]  <= 1'b1;
                    if (w_wake2[i])            r_rdy2[i]  <= 1'b1;
                end
                for (int j = 0; j < RS_DEPTH; j++) begin
                    if (w_disp_fire) begin
                        if (w_free_idx == IDX_W'(i))      r_older[i][j] <= r_valid[j];
                        else if (w_free_idx == IDX_W'(j)) r_older[i][j] <= 1'b0;
                    end
                end
            end
            case ({w_load, w_disp_fire})
                2'b10:   r_free_count <= r_free_count + 1'b1;
                2'b01:   r_free_count <= r_free_count - 1'b1;
                default: r_free_count <= r_free_count;
            endcase
        end
    end

    // entry payload, tags and operand values (no reset: qualified by r_valid)
    always_ff @(posedge clock) begin
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (w_disp_fire && (w_free_idx == IDX_W'(i))) begin
                r_payload[i] <= bus.disp_payload;
                r_tag[i]     <= bus.disp_tag;
                r_tag1[i]    <= bus.disp_rs1_tag;
                r_tag2[i]    <= bus.disp_rs2_tag;
                r_val1[i]    <= w_d_val1;
                r_val2[i]    <= w_d_val2;
            end else begin
                if (w_wake1[i]) r_val1[i] <= bus.cdb_value;
                if (w_wake2[i]) r_val2[i] <= bus.cdb_value;
            end
        end
    end

    // output stage valid: refill or drain when open, hold when stalled
    always_ff @(posedge clock) begin
        if (reset || bus.squash) begin
            r_issue_valid <= 1'b0;
        end else if (w_out_open) begin
            r_issue_valid <= w_any_elig;
        end
    end

    // output stage data: zeroed by reset, loaded only together with a selection
    always_ff @(posedge clock) begin
        if (reset) begin
            r_issue_payload <= '0;
            r_issue_tag     <= '0;
            r_issue_rs1     <= '0;
            r_issue_rs2     <= '0;
        end else if (!bus.squash && w_load) begin
            r_issue_payload <= r_payload[w_sel_idx];
            r_issue_tag     <= r_tag[w_sel_idx];
            r_issue_rs1     <= r_val1[w_sel_idx];
            r_issue_rs2     <= r_val2[w_sel_idx];
        end
    end

    assign bus.disp_ready      = w_disp_ready;
    assign bus.free_count      = r_free_count;
    assign bus.issue_valid     = r_issue_valid;
    assign bus.issue_payload   = r_issue_payload;
    assign bus.issue_tag       = r_issue_tag;
    assign bus.issue_rs1_value = r_issue_rs1;
    assign bus.issue_rs2_value = r_issue_rs2;
endmodule

// File: tb/tb_rs_multi_entry.sv
// Testbench for rs_multi_entry: directed scenarios followed by random traffic.
// A queue-based reference model predicts every issued instruction; a monitor
// compares each accepted issue against the head of the scoreboard queue.
module tb_rs_multi_entry;
    localparam int DEPTH = 8;
    localparam int XL    = 32;
    localparam int TW    = 5;
    localparam int PW    = 96;

    logic clock;
    logic reset;

    rs_multi_entry_if #(.RS_DEPTH(DEPTH), .XLEN(XL), .TAG_W(TW), .PAYLOAD_W(PW)) bus ();

    rs_multi_entry #(.RS_DEPTH(DEPTH), .XLEN(XL), .TAG_W(TW), .PAYLOAD_W(PW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [PW-1:0] pl;
        logic [TW-1:0] tag;
        bit            r1;
        bit            r2;
        logic [TW-1:0] t1;
        logic [TW-1:0] t2;
        logic [XL-1:0] v1;
        logic [XL-1:0] v2;
    } ent_t;

    typedef struct {
        logic [PW-1:0] pl;
        logic [TW-1:0] tag;
        logic [XL-1:0] v1;
        logic [XL-1:0] v2;
    } exp_t;

    ent_t mq[$];      // waiting instructions, oldest first
    exp_t sb[$];      // expected issue stream
    bit   m_out_valid;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: effect of the coming clock edge given the current inputs.
    task automatic model_step();
        int sel;
        int sz;
        ent_t e;
        exp_t x;
        if (reset || bus.squash) begin
            mq.delete();
            sb.delete();
            m_out_valid = 0;
            return;
        end
        sz = mq.size();
        if (!m_out_valid || bus.issue_ready) begin
            sel = -1;
            foreach (mq[i]) if (sel < 0 && mq[i].r1 && mq[i].r2) sel = i;
            if (sel >= 0) begin
                x.pl = mq[sel].pl; x.tag = mq[sel].tag; x.v1 = mq[sel].v1; x.v2 = mq[sel].v2;
                sb.push_back(x);
                mq.delete(sel);
                m_out_valid = 1;
            end else begin
                m_out_valid = 0;
            end
        end
        if (bus.cdb_valid) begin
            foreach (mq[i]) begin
                if (!mq[i].r1 && mq[i].t1 == bus.cdb_tag) begin mq[i].r1 = 1; mq[i].v1 = bus.cdb_value; end
                if (!mq[i].r2 && mq[i].t2 == bus.cdb_tag) begin mq[i].r2 = 1; mq[i].v2 = bus.cdb_value; end
            end
        end
        if (bus.disp_valid && sz < DEPTH) begin
            e.pl = bus.disp_payload; e.tag = bus.disp_tag;
            e.t1 = bus.disp_rs1_tag; e.t2 = bus.disp_rs2_tag;
            e.r1 = bus.disp_rs1_ready || (bus.cdb_valid && bus.cdb_tag == bus.disp_rs1_tag);
            e.r2 = bus.disp_rs2_ready || (bus.cdb_valid && bus.cdb_tag == bus.disp_rs2_tag);
            e.v1 = bus.disp_rs1_ready ? bus.disp_rs1_value : bus.cdb_value;
            e.v2 = bus.disp_rs2_ready ? bus.disp_rs2_value : bus.cdb_value;
            mq.push_back(e);
        end
    endtask

    // Compare registered outputs with the model, apply the edge to the model, advance.
    task automatic do_cycle();
        chk("free_count", 128'(bus.free_count), 128'(DEPTH - mq.size()));
        chk("disp_ready", 128'(bus.disp_ready), 128'(mq.size() < DEPTH));
        chk("issue_valid", 128'(bus.issue_valid), 128'(m_out_valid));
        model_step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        reset = 0;
        bus.squash = 0;
        bus.disp_valid = 0;
        bus.cdb_valid = 0;
    endtask

    task automatic disp(input logic [TW-1:0] tag,
                        input bit r1, input logic [XL-1:0] v1, input logic [TW-1:0] t1,
                        input bit r2, input logic [XL-1:0] v2, input logic [TW-1:0] t2);
        bus.disp_valid     = 1;
        bus.disp_payload   = {$urandom, $urandom, $urandom};
        bus.disp_tag       = tag;
        bus.disp_rs1_ready = r1; bus.disp_rs1_value = v1; bus.disp_rs1_tag = t1;
        bus.disp_rs2_ready = r2; bus.disp_rs2_value = v2; bus.disp_rs2_tag = t2;
    endtask

    task automatic cdb(input logic [TW-1:0] tag, input logic [XL-1:0] val);
        bus.cdb_valid = 1;
        bus.cdb_tag   = tag;
        bus.cdb_value = val;
    endtask

    // Scoreboard monitor: an issue is accepted on the coming edge when valid && ready.
    always @(negedge clock) begin
        exp_t e;
        if (!reset && !bus.squash && bus.issue_valid === 1'b1 && bus.issue_ready === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_issue_tag", 128'(bus.issue_tag), 128'hFFFF);
            end else begin
                e = sb.pop_front();
                chk("issue_tag", 128'(bus.issue_tag), 128'(e.tag));
                chk("issue_payload", 128'(bus.issue_payload), 128'(e.pl));
                chk("issue_rs1", 128'(bus.issue_rs1_value), 128'(e.v1));
                chk("issue_rs2", 128'(bus.issue_rs2_value), 128'(e.v2));
            end
        end
    end

    logic [PW-1:0] snap_pl;
    logic [TW-1:0] snap_tag;
    logic [XL-1:0] snap_v1;
    logic [XL-1:0] snap_v2;

    initial begin
        reset = 1;
        bus.squash = 0; bus.disp_valid = 0; bus.cdb_valid = 0; bus.issue_ready = 0;
        bus.disp_payload = '0; bus.disp_tag = '0;
        bus.disp_rs1_ready = 0; bus.disp_rs2_ready = 0;
        bus.disp_rs1_value = '0; bus.disp_rs2_value = '0;
        bus.disp_rs1_tag = '0; bus.disp_rs2_tag = '0;
        bus.cdb_tag = '0; bus.cdb_value = '0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_issue_valid", 128'(bus.issue_valid), 128'd0);
        chk("rst_issue_tag", 128'(bus.issue_tag), 128'd0);
        chk("rst_issue_payload", 128'(bus.issue_payload), 128'd0);
        chk("rst_issue_rs1", 128'(bus.issue_rs1_value), 128'd0);
        chk("rst_issue_rs2", 128'(bus.issue_rs2_value), 128'd0);
        chk("rst_free_count", 128'(bus.free_count), 128'd8);
        chk("rst_disp_ready", 128'(bus.disp_ready), 128'd1);
        m_out_valid = 0;
        idle();

        // 1: ready-at-dispatch instruction reaches the output stage two edges later
        bus.issue_ready = 1;
        disp(5'd3, 1, 32'd5, 5'd0, 1, 32'd7, 5'd0);
        do_cycle();
        idle();
        do_cycle();
        chk("t1_issue_valid", 128'(bus.issue_valid), 128'd1);
        chk("t1_issue_tag", 128'(bus.issue_tag), 128'd3);
        repeat (3) do_cycle();

        // 2: tag 0 is an ordinary producer tag; younger ready entry goes first
        disp(5'd1, 0, 32'd0, 5'd0, 1, 32'd11, 5'd0);
        do_cycle();
        disp(5'd2, 1, 32'd21, 5'd0, 1, 32'd22, 5'd0);
        do_cycle();
        idle();
        cdb(5'd0, 32'hAA);
        do_cycle();
        idle();
        repeat (4) do_cycle();

        // 3: fill all entries waiting on tag 9, a ninth dispatch is dropped
        for (int i = 0; i < DEPTH; i++) begin
            disp(TW'(i + 16), 0, 32'd0, 5'd9, 1, 32'(i), 5'd0);
            do_cycle();
        end
        chk("t3_full_disp_ready", 128'(bus.disp_ready), 128'd0);
        chk("t3_full_free_count", 128'(bus.free_count), 128'd0);
        disp(5'd30, 1, 32'd1, 5'd0, 1, 32'd1, 5'd0);
        do_cycle();
        idle();
        cdb(5'd9, 32'h1234_5678);
        do_cycle();
        idle();
        repeat (12) do_cycle();

        // 4: stalled output stage keeps its contents stable
        bus.issue_ready = 0;
        disp(5'd20, 1, 32'hA0, 5'd0, 1, 32'hB0, 5'd0);
        do_cycle();
        disp(5'd21, 1, 32'hA1, 5'd0, 1, 32'hB1, 5'd0);
        do_cycle();
        idle();
        snap_pl = bus.issue_payload; snap_tag = bus.issue_tag;
        snap_v1 = bus.issue_rs1_value; snap_v2 = bus.issue_rs2_value;
        chk("t4_tag", 128'(snap_tag), 128'd20);
        for (int k = 0; k < 3; k++) begin
            do_cycle();
            chk("t4_hold_tag", 128'(bus.issue_tag), 128'(snap_tag));
            chk("t4_hold_payload", 128'(bus.issue_payload), 128'(snap_pl));
            chk("t4_hold_rs1", 128'(bus.issue_rs1_value), 128'(snap_v1));
            chk("t4_hold_rs2", 128'(bus.issue_rs2_value), 128'(snap_v2));
            chk("t4_hold_free", 128'(bus.free_count), 128'd7);
        end
        bus.issue_ready = 1;
        repeat (4) do_cycle();

        // 5: dispatch catches the broadcast of its own producer tag
        disp(5'd25, 0, 32'd0, 5'd4, 1, 32'd3, 5'd0);
        cdb(5'd4, 32'h55);
        do_cycle();
        idle();
        repeat (4) do_cycle();

        // 6: squash with a loaded output stage and five waiting entries drops a dispatch
        bus.issue_ready = 0;
        disp(5'd11, 1, 32'd1, 5'd0, 1, 32'd2, 5'd0);
        do_cycle();
        for (int i = 0; i < 5; i++) begin
            disp(TW'(12 + i), 0, 32'd0, 5'd10, 1, 32'd9, 5'd0);
            do_cycle();
        end
        idle();
        do_cycle();
        bus.squash = 1;
        disp(5'd17, 1, 32'd4, 5'd0, 1, 32'd4, 5'd0);
        do_cycle();
        idle();
        chk("t6_issue_valid", 128'(bus.issue_valid), 128'd0);
        chk("t6_free_count", 128'(bus.free_count), 128'd8);
        bus.issue_ready = 1;
        repeat (3) do_cycle();

        // random traffic with occasional squash and one mid-run reset
        for (int c = 0; c < 3000; c++) begin
            bus.disp_valid     = ($urandom_range(0, 3) != 0);
            bus.disp_payload   = {$urandom, $urandom, $urandom};
            bus.disp_tag       = TW'($urandom_range(0, 31));
            bus.disp_rs1_ready = ($urandom_range(0, 2) == 0);
            bus.disp_rs2_ready = ($urandom_range(0, 2) == 0);
            bus.disp_rs1_value = $urandom;
            bus.disp_rs2_value = $urandom;
            bus.disp_rs1_tag   = TW'($urandom_range(0, 7));
            bus.disp_rs2_tag   = TW'($urandom_range(0, 7));
            bus.cdb_valid      = ($urandom_range(0, 1) == 1);
            bus.cdb_tag        = TW'($urandom_range(0, 7));
            bus.cdb_value      = $urandom;
            bus.issue_ready    = ((c / 256) % 2 == 0) ? ($urandom_range(0, 3) == 0)
                                                      : ($urandom_range(0, 3) != 0);
            bus.squash         = ($urandom_range(0, 99) == 0);
            reset              = (c == 1500);
            do_cycle();
        end

        // drain: sweep every tag on the CDB with the FU always ready
        idle();
        bus.issue_ready = 1;
        for (int c = 0; c < 80; c++) begin
            cdb(TW'(c % 32), $urandom);
            do_cycle();
        end
        idle();
        repeat (4) do_cycle();
        chk("drain_free_count", 128'(bus.free_count), 128'd8);
        chk("drain_issue_valid", 128'(bus.issue_valid), 128'd0);
        chk("drain_scoreboard_left", 128'(sb.size()), 128'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
